// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampled UART receiver with a single-entry holding register and error flags
module uart_rx_ctrl #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   input  logic            s_tick,
   input  logic            rd_uart,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_empty,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            overrun_err
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg, state_next;
   logic [4:0]      s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            rx_meta, rx_sync;
   logic            frame_done;

   // two-flop synchronizer for the asynchronous serial line, idle-high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // FSM and bit-level counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
      end
   end

   // next-state logic: everything except leaving IDLE waits for an oversampling tick
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      frame_done = 1'b0;
      case (state_reg)
         IDLE:
            if (!rx_sync) begin
               state_next = START;
               s_next     = '0;
            end
         START:
            if (s_tick) begin
               if (s_reg == 5'd7) begin
                  state_next = rx_sync ? IDLE : DATA;
                  s_next     = '0;
                  n_next     = '0;
               end else
                  s_next = s_reg + 5'd1;
            end
         DATA:
            if (s_tick) begin
               if (s_reg == 5'd15) begin
                  s_next = '0;
                  b_next = {rx_sync, b_reg[DBIT-1:1]};
                  if (n_reg == NW'(DBIT - 1))
                     state_next = STOP;
                  else
                     n_next = n_reg + NW'(1);
               end else
                  s_next = s_reg + 5'd1;
            end
         STOP:
            if (s_tick) begin
               if (s_reg == 5'(SB_TICK - 1)) begin
                  state_next = IDLE;
                  frame_done = 1'b1;
               end else
                  s_next = s_reg + 5'd1;
            end
         default:
            state_next = IDLE;
      endcase
   end

   // holding register: a completed frame always loads; a pop on the same cycle cancels the overrun
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data      <= '0;
         rx_empty     <= 1'b1;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         rx_done_tick <= frame_done;
         if (frame_done) begin
            rx_data   <= b_reg;
            rx_empty  <= 1'b0;
            frame_err <= ~rx_sync;
            if (!rx_empty)
               overrun_err <= ~rd_uart;
         end else if (rd_uart && !rx_empty) begin
            rx_empty    <= 1'b1;
            overrun_err <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the 16x oversampling tick produced by the baud tick timer to deserialize asynchronous frames. It detects the start bit, samples data bits mid-period LSB-first, checks the stop bit, and holds the received word in a single-entry buffer. A host reads the buffer through a pop handshake, and the block flags framing and overrun errors.

## Interface

Parameters:
- DBIT, 8: data bits per frame, range 5..9.
- SB_TICK, 16: s_tick count for the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous, idle high.
- s_tick  in  1  one-clk pulse at 16x baud, from the baud tick timer's done output.
- rd_uart  in  1  pop request for the holding register.
- rx_data  out  DBIT  holding register, LSB = first received bit.
- rx_empty  out  1  high when the holding register has no unread word.
- rx_done_tick  out  1  one-clk pulse on each completed frame.
- frame_err  out  1  stop bit of the last loaded frame sampled low.
- overrun_err  out  1  sticky: a frame completed while the holding register was full.

## Operation

- rx passes through a 2-flop synchronizer (rx_sync). Both flops reset to 1. All decisions use rx_sync.
- Counters:
  - s, 5 bits: tick count within a bit.
  - n, clog2(DBIT) bits: data bit index.
  - b, DBIT bits: shift register.
- Counters and state advance only on cycles with s_tick=1. The exception is the IDLE exit, which needs no tick.
- FSM states and transitions:
  - IDLE: on rx_sync==0, go to START with s=0. s_tick is ignored.
  - START: on tick with s==7 (mid start bit), check rx_sync.
    - rx_sync==0: go to DATA with s=0, n=0.
    - rx_sync==1: false start, return to IDLE with no output activity.
    - Otherwise on a tick, s++.
  - DATA: on tick with s==15, set s=0 and b={rx_sync, b[DBIT-1:1]}.
    - If n==DBIT-1, go to STOP.
    - Else n++.
    - Otherwise on a tick, s++.
  - STOP: on tick with s==SB_TICK-1, go to IDLE and complete the frame. Stop bit value = rx_sync at that tick. Otherwise on a tick, s++.
- Frame completion:
  - rx_data<=b, rx_empty<=0, frame_err<=~rx_sync, rx_done_tick<=1 for one cycle.
  - Frames with a framing error are still loaded.
- Holding register and pop:
  - rd_uart with rx_empty=0: rx_empty<=1 and overrun_err<=0.
  - rd_uart with rx_empty=1: ignored.
  - rx_data keeps its value after a pop.
- Overrun: a frame completes with rx_empty=0 and no rd_uart in the same cycle.
  - New word overwrites rx_data and frame_err.
  - overrun_err<=1, sticky until the next pop.
- Simultaneous rd_uart and frame completion: the new word is loaded, rx_empty stays 0, and no overrun is flagged.
- rx activity while a word is buffered does not stall reception.

## Timing

- Reset values:
  - FSM = IDLE; s, n, b = 0.
  - rx_data = 0, rx_empty = 1.
  - rx_done_tick = 0, frame_err = 0, overrun_err = 0.
  - Synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. The partial word is discarded and the holding register is cleared.
- All outputs are registered.
- rx falling edge to START entry: 3 clk (2 sync + 1 state register).
- Sampling instants:
  - start-bit check at the 8th tick after START entry;
  - data bit k at the 16*(k+1)+8th tick;
  - stop bit at the 16*DBIT+8+SB_TICK-th tick.
- rx_done_tick, rx_data, rx_empty and frame_err all update on the clk edge that consumes the final stop-period tick.
- Earliest next start detection: the cycle after the return to IDLE.
- s_tick held high continuously is legal: one tick per clk.

## Test plan

- Frame 0xA5, 1 stop bit, s_tick every 10 clk, 16 ticks/bit.
  - Required: rx_done_tick pulses once; rx_data=0xA5, rx_empty=0, frame_err=0.
  - Then rd_uart for 1 clk gives rx_empty=1.
- Glitch: rx low for 5 ticks, then high.
  - Required: FSM returns to IDLE and rx_done_tick never asserts.
  - A following frame 0x3C is still received correctly.
- Frame 0x81 with the stop bit driven low.
  - Required: rx_data=0x81, frame_err=1, rx_empty=0.
  - The next good frame 0x00 after a pop clears frame_err.
- Two frames 0x11 then 0x22 with no pop.
  - Required: rx_data=0x22 and overrun_err=1.
  - rd_uart clears overrun_err and sets rx_empty=1.
- rd_uart asserted on the exact cycle of 0x22's completion, with 0x11 buffered.
  - Required: rx_data=0x22, rx_empty=0, overrun_err=0.
- reset_n pulsed low during DATA bit 4 of 0xFF.
  - Required: all outputs take their reset values asynchronously and no rx_done_tick occurs.
  - A following frame 0x5A is received correctly.
